// File: rtl/adc_spi_responder.sv
// SPI responder emulating an 8-channel 12-bit serial ADC on the clk_50 domain.
// Answers 16-clock frames: captures a 3-bit address on DIN, returns the previously addressed channel on DOUT.
module adc_spi_responder #(
  parameter int CLK_DIV_MIN = 4
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        spi_clk,
  input  logic        spi_cs_n,
  input  logic        spi_din,
  output logic        spi_dout,
  output logic        spi_dout_oe,
  input  logic        wr_en,
  input  logic [2:0]  wr_chan,
  input  logic [11:0] wr_data,
  output logic        frame_done,
  output logic        frame_abort,
  output logic [2:0]  cur_chan,
  output logic [15:0] frame_count
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t      state;
  logic [2:0]  clk_sync;
  logic [2:0]  cs_sync;
  logic [1:0]  din_sync;
  logic [15:0] shreg;
  logic [3:0]  bit_cnt;
  logic [2:0]  next_addr;
  logic [11:0] regfile [8];
  logic [7:0]  sclk_gap;

  logic cs_fall, cs_rise, sclk_rise, sclk_fall;

  // Synchronizers reset to the bus idle levels so no edge is seen on release.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      clk_sync <= '1;
      cs_sync  <= '1;
      din_sync <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      clk_sync <= {clk_sync[1:0], spi_clk};
      cs_sync  <= {cs_sync[1:0], spi_cs_n};
      din_sync <= {din_sync[0], spi_din};
    end
  end

  assign cs_fall   =  cs_sync[2] & ~cs_sync[1];
  assign cs_rise   = ~cs_sync[2] &  cs_sync[1];
  assign sclk_rise = ~cs_sync[1] &  clk_sync[1] & ~clk_sync[2];
  assign sclk_fall = ~cs_sync[1] & ~clk_sync[1] &  clk_sync[2];

  // NOTE: the register file is only 8 entries and must read as zero after reset, so it lives in resettable flops.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regfile[i] <= '0;
    end else if (wr_en) begin
      regfile[wr_chan] <= wr_data;
    end
  end

  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      shreg       <= '0;
      bit_cnt     <= '0;
      next_addr   <= '0;
      cur_chan    <= '0;
      frame_count <= '0;
      spi_dout    <= 1'b0;
      spi_dout_oe <= 1'b0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
    end else begin
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (cs_fall) begin
            state       <= ACTIVE;
            shreg       <= {4'b0, regfile[cur_chan]};
            bit_cnt     <= '0;
            spi_dout_oe <= 1'b1;
            spi_dout    <= 1'b0;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state       <= IDLE;
            spi_dout_oe <= 1'b0;
            spi_dout    <= 1'b0;
            if (bit_cnt != 4'd0) frame_abort <= 1'b1;
          end else if (sclk_rise) begin
            case (bit_cnt)
              4'd2:    next_addr[2] <= din_sync[1];
              4'd3:    next_addr[1] <= din_sync[1];
              4'd4:    next_addr[0] <= din_sync[1];
              default: ;
            endcase
            if (bit_cnt == 4'd15) begin
              // Address bits are only captured at counts 2..4, so next_addr is already final here.
              cur_chan    <= next_addr;
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              shreg       <= {4'b0, regfile[next_addr]};
              spi_dout    <= 1'b0;
              bit_cnt     <= '0;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (sclk_fall && bit_cnt != 4'd0) begin
            shreg    <= {shreg[14:0], 1'b0};
            spi_dout <= shreg[14];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Cycles since the last qualified SCLK edge (or CS fall), saturating; only feeds the timing check.
  always_ff @(posedge clk_50 or posedge reset) begin
    if (reset) begin
      sclk_gap <= '0;
    end else if (cs_fall || sclk_rise || sclk_fall) begin
      sclk_gap <= '0;
    end else if (sclk_gap != 8'hFF) begin
      sclk_gap <= sclk_gap + 8'd1;
    end
  end

  sclk_half_period_a: assert property (@(posedge clk_50) disable iff (reset)
    (state == ACTIVE && !cs_rise && (sclk_rise || sclk_fall)) |-> (int'(sclk_gap) >= CLK_DIV_MIN - 1));

endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: a bit-banged SPI master plus a transaction-level ADC model.
module tb_adc_spi_responder;

  localparam int HP = 8;

  logic        clk_50 = 1'b0;
  logic        reset;
  logic        spi_clk, spi_cs_n, spi_din;
  logic        spi_dout, spi_dout_oe;
  logic        wr_en;
  logic [2:0]  wr_chan;
  logic [11:0] wr_data;
  logic        frame_done, frame_abort;
  logic [2:0]  cur_chan;
  logic [15:0] frame_count;

  adc_spi_responder #(.CLK_DIV_MIN(4)) dut (
    .clk_50      (clk_50),
    .reset       (reset),
    .spi_clk     (spi_clk),
    .spi_cs_n    (spi_cs_n),
    .spi_din     (spi_din),
    .spi_dout    (spi_dout),
    .spi_dout_oe (spi_dout_oe),
    .wr_en       (wr_en),
    .wr_chan     (wr_chan),
    .wr_data     (wr_data),
    .frame_done  (frame_done),
    .frame_abort (frame_abort),
    .cur_chan    (cur_chan),
    .frame_count (frame_count)
  );

  always #10 clk_50 = ~clk_50;

  int n_checks = 0;
  int n_fails  = 0;

  // Transaction-level model of the emulated ADC.
  logic [11:0] m_reg [8];
  logic [2:0]  m_chan;
  logic [15:0] m_count;
  logic        m_oe;
  bit          settled;
  int          n_done, n_abort, e_done, e_abort;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_50);
  endtask

  task automatic wr(input logic [2:0] ch, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_chan = ch;
    wr_data = d;
    @(negedge clk_50);
    wr_en   = 1'b0;
    m_reg[ch] = d;
  endtask

  // Every-cycle comparison of the steady outputs against the model, plus pulse counting.
  logic prev_done = 1'b0, prev_abort = 1'b0;
  always @(negedge clk_50) begin
    if (reset) begin
      prev_done  = 1'b0;
      prev_abort = 1'b0;
    end else begin
      if (prev_done)  check("done_width", 32'(frame_done), 32'd0);
      if (prev_abort) check("abort_width", 32'(frame_abort), 32'd0);
      if (frame_done)  n_done++;
      if (frame_abort) n_abort++;
      prev_done  = frame_done;
      prev_abort = frame_abort;
      if (settled) begin
        check("mon cur_chan", 32'(cur_chan), 32'(m_chan));
        check("mon frame_count", 32'(frame_count), 32'(m_count));
        check("mon oe", 32'(spi_dout_oe), 32'(m_oe));
        if (!m_oe) check("mon dout_idle", 32'(spi_dout), 32'd0);
      end
    end
  end

  // One CS-low transfer of nr SCLK cycles; addresses a0 then a1 (second frame when nr > 16).
  task automatic xfer(input string tag, input logic [2:0] a0, input logic [2:0] a1, input int nr,
                      input bit mid_wr, input logic [11:0] mid_d, output logic [31:0] rx);
    logic [15:0] exp_w;
    logic [2:0]  a;
    int          k;
    rx    = '0;
    exp_w = {4'b0, m_reg[m_chan]};
    settled  = 1'b0;
    spi_cs_n = 1'b0;
    wait_cyc(HP);
    m_oe    = 1'b1;
    settled = 1'b1;
    if (mid_wr) wr(m_chan, mid_d);
    for (int i = 0; i < nr; i++) begin
      a = (i < 16) ? a0 : a1;
      spi_clk = 1'b0;
      case (i % 16)
        2:       spi_din = a[2];
        3:       spi_din = a[1];
        4:       spi_din = a[0];
        default: spi_din = 1'b0;
      endcase
      wait_cyc(HP);
      rx = {rx[30:0], spi_dout};
      spi_clk = 1'b1;
      if (i % 16 == 15) begin
        settled = 1'b0;
        for (int p = 0; p < 4; p++) begin
          @(posedge clk_50); #1;
          check($sformatf("%s done_lat%0d", tag, p), 32'(frame_done), (p == 2) ? 32'd1 : 32'd0);
        end
        @(negedge clk_50);
        check($sformatf("%s data", tag), 32'(rx[15:0]), 32'(exp_w));
        m_chan = a;
        m_count++;
        e_done++;
        exp_w = {4'b0, m_reg[m_chan]};
        settled = 1'b1;
        wait_cyc(HP - 4);
      end else begin
        wait_cyc(HP);
      end
    end
    k = nr % 16;
    if (k != 0)
      check($sformatf("%s partial", tag), rx & ((32'd1 << k) - 32'd1), 32'(exp_w >> (16 - k)));
    settled  = 1'b0;
    spi_cs_n = 1'b1;
    spi_din  = 1'b0;
    @(posedge clk_50); #1;
    @(posedge clk_50); #1;
    check($sformatf("%s oe_hold", tag), 32'(spi_dout_oe), 32'd1);
    @(posedge clk_50); #1;
    check($sformatf("%s oe_off", tag), 32'(spi_dout_oe), 32'd0);
    check($sformatf("%s abort", tag), 32'(frame_abort), (k != 0) ? 32'd1 : 32'd0);
    @(negedge clk_50);
    if (k != 0) e_abort++;
    m_oe = 1'b0;
    wait_cyc(HP);
    settled = 1'b1;
    check($sformatf("%s n_done", tag), 32'(n_done), 32'(e_done));
    check($sformatf("%s n_abort", tag), 32'(n_abort), 32'(e_abort));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_chan  = '0;
    m_count = '0;
    m_oe    = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " dout"}, 32'(spi_dout), 32'd0);
    check({tag, " oe"}, 32'(spi_dout_oe), 32'd0);
    check({tag, " done"}, 32'(frame_done), 32'd0);
    check({tag, " abort"}, 32'(frame_abort), 32'd0);
    check({tag, " cur_chan"}, 32'(cur_chan), 32'd0);
    check({tag, " frame_count"}, 32'(frame_count), 32'd0);
  endtask

  logic [31:0] rx;

  initial begin
    settled  = 1'b0;
    n_done = 0; n_abort = 0; e_done = 0; e_abort = 0;
    reset    = 1'b1;
    spi_clk  = 1'b1;
    spi_cs_n = 1'b1;
    spi_din  = 1'b0;
    wr_en    = 1'b0;
    wr_chan  = '0;
    wr_data  = '0;
    model_reset();
    wait_cyc(3);
    check_reset_outputs("in_reset");
    reset = 1'b0;
    wait_cyc(5);
    check_reset_outputs("post_reset");
    settled = 1'b1;

    // Single frame: ch0 returned, address 5 captured.
    wr(3'd0, 12'hABC);
    xfer("single", 3'd5, 3'd0, 16, 1'b0, 12'h0, rx);
    check("single rx", 32'(rx[15:0]), 32'h0ABC);
    check("single cur_chan", 32'(cur_chan), 32'd5);
    check("single count", 32'(frame_count), 32'd1);

    // Address pipelining: returns ch5, then points at ch2.
    wr(3'd5, 12'h123);
    xfer("pipe", 3'd2, 3'd0, 16, 1'b0, 12'h0, rx);
    check("pipe rx", 32'(rx[15:0]), 32'h0123);
    check("pipe cur_chan", 32'(cur_chan), 32'd2);

    // Continuous CS: two back-to-back frames.
    xfer("to_ch0", 3'd0, 3'd0, 16, 1'b0, 12'h0, rx);
    check("to_ch0 rx", 32'(rx[15:0]), 32'h0000);
    wr(3'd0, 12'h111);
    wr(3'd7, 12'hFFF);
    xfer("cont", 3'd7, 3'd0, 32, 1'b0, 12'h0, rx);
    check("cont rx", rx, 32'h0111_0FFF);
    check("cont n_done", 32'(n_done), 32'd5);
    check("cont n_abort", 32'(n_abort), 32'd0);
    check("cont count", 32'(frame_count), 32'd5);

    // Abort after 9 rises: channel unchanged, same channel returned next.
    xfer("abort", 3'd3, 3'd0, 9, 1'b0, 12'h0, rx);
    check("abort rx9", 32'(rx[8:0]), 32'h002);
    check("abort n_abort", 32'(n_abort), 32'd1);
    check("abort cur_chan", 32'(cur_chan), 32'd0);
    check("abort count", 32'(frame_count), 32'd5);
    xfer("after_abort", 3'd0, 3'd0, 16, 1'b0, 12'h0, rx);
    check("after_abort rx", 32'(rx[15:0]), 32'h0111);

    // Snapshot: a write during the frame does not disturb it.
    wr(3'd0, 12'h0AA);
    xfer("snap", 3'd6, 3'd0, 16, 1'b1, 12'h555, rx);
    check("snap rx", 32'(rx[15:0]), 32'h00AA);
    xfer("snap_next", 3'd6, 3'd0, 16, 1'b0, 12'h0, rx);
    check("snap_next rx", 32'(rx[15:0]), 32'h0000);
    check("snap count", 32'(frame_count), 32'd8);
    xfer("snap_ch6_to0", 3'd0, 3'd0, 16, 1'b0, 12'h0, rx);
    xfer("snap_ch0", 3'd6, 3'd0, 16, 1'b0, 12'h0, rx);
    check("snap_ch0 rx", 32'(rx[15:0]), 32'h0555);
    check("snap_ch0 cur_chan", 32'(cur_chan), 32'd6);

    // Reset in the middle of a frame.
    settled  = 1'b0;
    spi_cs_n = 1'b0;
    wait_cyc(HP);
    for (int i = 0; i < 7; i++) begin
      spi_clk = 1'b0;
      wait_cyc(HP);
      spi_clk = 1'b1;
      wait_cyc(HP);
    end
    check("pre_rst oe", 32'(spi_dout_oe), 32'd1);
    check("pre_rst cur_chan", 32'(cur_chan), 32'd6);
    reset = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    model_reset();
    spi_cs_n = 1'b1;
    spi_clk  = 1'b1;
    spi_din  = 1'b0;
    wait_cyc(4);
    reset = 1'b0;
    wait_cyc(6);
    settled = 1'b1;
    xfer("post_rst0", 3'd5, 3'd0, 16, 1'b0, 12'h0, rx);
    check("post_rst0 rx", 32'(rx[15:0]), 32'h0000);
    check("post_rst0 count", 32'(frame_count), 32'd1);
    xfer("post_rst1", 3'd0, 3'd0, 16, 1'b0, 12'h0, rx);
    check("post_rst1 rx", 32'(rx[15:0]), 32'h0000);
    check("post_rst1 count", 32'(frame_count), 32'd2);

    settled = 1'b0;
    wait_cyc(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
